mips_clz_dec: RTL and testbench
===============================

MIPS_CLZ_DEC -- requirements
Module: mips_clz_dec

Interface
REQ-001 Parameter DATA_WIDTH, default 32, decoded word width in bits.
REQ-002 Parameter DATA_WIDTH_LOG2, default 5, log2(DATA_WIDTH); count fields are DATA_WIDTH_LOG2+1 bits.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port vld_i  input  1  request valid.
REQ-006 Port rdy_o  output  1  request ready; driven directly from a register.
REQ-007 Port cnt_i  input  DATA_WIDTH_LOG2+1  leading-zero count to decode.
REQ-008 Port mode_i  input  2  00 one-hot, 01 leading-zero mask, 10 leading-one mask, 11 reserved.
REQ-009 Port vld_o  output  1  result valid.
REQ-010 Port rdy_i  input  1  result ready from the consumer.
REQ-011 Port data_o  output  DATA_WIDTH  decoded word.
REQ-012 Port sat_o  output  1  set when cnt_i > DATA_WIDTH; the count was saturated.

Function
REQ-013 Block SHALL decode a count into a word, the inverse of the CLZ unit; n = min(cnt_i, DATA_WIDTH).
REQ-014 Mode 00 SHALL set only bit DATA_WIDTH-1-n; n = DATA_WIDTH gives all zeros.
REQ-015 Mode 01 SHALL clear the top n bits and set all remaining bits; n = DATA_WIDTH gives all zeros.
REQ-016 Mode 10 SHALL set the top n bits and clear all remaining bits; n = DATA_WIDTH gives all ones.
REQ-017 Mode 11 SHALL decode identically to mode 00.
REQ-018 sat_o SHALL be 1 iff cnt_i > DATA_WIDTH; 6-bit cnt_i values 33..63 saturate to 32.
REQ-019 A request SHALL be accepted on a rising edge with vld_i & rdy_o.
REQ-020 Datapath: one output register (vld_o/data_o/sat_o) plus one skid register.
REQ-021 Latency SHALL be 1 cycle: an accepted request appears on vld_o/data_o in the next cycle if the output register is empty or consumed that edge.
REQ-022 Otherwise the accepted request SHALL go into the skid register, and rdy_o SHALL be 0 from the next cycle.
REQ-023 Output handshake: a result retires on a rising edge with vld_o & rdy_i.
REQ-024 While vld_o & ~rdy_i, data_o and sat_o SHALL hold stable.
REQ-025 When the output retires and the skid is full, the skid entry SHALL move to the output register on that edge.
REQ-026 In that case rdy_o SHALL be 1 from the next cycle.
REQ-027 rdy_o SHALL equal ~skid_valid.
REQ-028 Sustained throughput SHALL be 1 result per cycle when rdy_i = 1.
REQ-029 Results SHALL leave in request order; none dropped or duplicated.
REQ-030 Accept and retire on the same edge SHALL be legal in every occupancy state.
REQ-031 With the output register full and the skid empty, same-edge accept and retire SHALL load the new result into the output register; the skid stays empty.
REQ-032 Inputs while vld_i = 0 or rdy_o = 0 SHALL be ignored.
REQ-033 Occupancy SHALL be 0, 1 or 2 entries; no other state exists.

Reset
REQ-034 While rst = 1, all registers SHALL be cleared immediately, independent of clk.
REQ-035 Reset values: vld_o 0, data_o 0, sat_o 0, skid_valid 0, so rdy_o = 1.
REQ-036 Reset mid-operation SHALL discard all in-flight results; none appears after rst falls.
REQ-037 The first request SHALL be acceptable on the first rising edge after rst deasserts.

Verification
REQ-038 mode 00, cnt_i=0 -> next cycle vld_o=1, data_o=0x8000_0000, sat_o=0; with cnt_i=31 -> 0x0000_0001.
REQ-039 cnt_i=5: mode 01 -> 0x07FF_FFFF; mode 10 -> 0xF800_0000; mode 11 -> 0x0400_0000.
REQ-040 Boundaries:
- cnt_i=32, mode 01 -> 0x0000_0000, sat_o=0.
- cnt_i=40, mode 10 -> 0xFFFF_FFFF, sat_o=1.
- cnt_i=63, mode 00 -> 0x0000_0000, sat_o=1.
REQ-041 Backpressure: rdy_i=0; send A (cnt 1), B (cnt 2) back-to-back.
- rdy_o drops after B; C is held off.
- Raising rdy_i yields A, then B, then C, with no gaps.
REQ-042 Reset mid-operation: with both entries full, pulse rst between edges.
- vld_o=0 and rdy_o=1 immediately.
- No stale output after release.
REQ-043 Round trip: mode 00 outputs for cnt_i 0..32 fed to the CLZ unit return the original count (32 -> 6'b100000).
- Random streams with random rdy_i keep order against a reference model.

Source files
------------

// File: rtl/mips_clz_dec.sv
// Count-to-word decoder (inverse of the CLZ unit) behind a one-deep output
// register plus a skid register, with valid/ready on both sides.
module mips_clz_dec #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_LOG2 = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld_i,
    output logic                       rdy_o,
    input  logic [DATA_WIDTH_LOG2:0]   cnt_i,
    input  logic [1:0]                 mode_i,
    output logic                       vld_o,
    input  logic                       rdy_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       sat_o
);
    localparam int CW = DATA_WIDTH_LOG2 + 1;
    localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);

    logic                  dec_sat;
    logic [CW-1:0]         dec_n;
    logic [CW-1:0]         pos;
    logic [DATA_WIDTH-1:0] lead1;
    logic [DATA_WIDTH-1:0] onehot;
    logic [DATA_WIDTH-1:0] dec_data;

    // Bit i lies in the top n bits when its distance from the MSB is below n.
    always_comb begin
        dec_sat  = cnt_i > DW_C;
        dec_n    = dec_sat ? DW_C : cnt_i;
        pos      = '0;
        lead1    = '0;
        onehot   = '0;
        dec_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos       = CW'(DATA_WIDTH - 1 - i);
            lead1[i]  = pos < dec_n;
            onehot[i] = pos == dec_n;
        end
        case (mode_i)
            2'b01:   dec_data = ~lead1;
            2'b10:   dec_data = lead1;
            default: dec_data = onehot;
        endcase
    end

    logic                  out_vld_q,  out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sat_q,  out_sat_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_sat_q, skid_sat_d;
    logic                  rdy_q, rdy_d;
    logic                  accept;
    logic                  out_free;

    assign accept   = vld_i & rdy_q;
    assign out_free = ~out_vld_q | rdy_i;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_sat_d  = skid_sat_q;
        if (out_free) begin
            // A full skid blocks new requests, so it alone refills the output.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_sat_d  = skid_sat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_data_d = dec_data;
                    out_sat_d  = dec_sat;
                end
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = dec_data;
            skid_sat_d  = dec_sat;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sat_q  <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_sat_q  <= skid_sat_d;
            rdy_q       <= rdy_d;
        end
    end

    assign rdy_o  = rdy_q;
    assign vld_o  = out_vld_q;
    assign data_o = out_data_q;
    assign sat_o  = out_sat_q;
endmodule

// File: tb/tb_mips_clz_dec.sv
// Bench for mips_clz_dec: queue-based reference model checked every cycle,
// plus directed literal vectors, backpressure, reset and CLZ round trip.
module tb_mips_clz_dec;
    localparam int DW = 32;
    localparam int LG = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld_i;
    logic          rdy_o;
    logic [LG:0]   cnt_i;
    logic [1:0]    mode_i;
    logic          vld_o;
    logic          rdy_i;
    logic [DW-1:0] data_o;
    logic          sat_o;

    int n_chk  = 0;
    int n_fail = 0;

    mips_clz_dec #(.DATA_WIDTH(DW), .DATA_WIDTH_LOG2(LG)) dut (
        .clk(clk), .rst(rst), .vld_i(vld_i), .rdy_o(rdy_o), .cnt_i(cnt_i),
        .mode_i(mode_i), .vld_o(vld_o), .rdy_i(rdy_i), .data_o(data_o),
        .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_dec(input int cnt, input int mode);
        longint ones = (64'd1 << DW) - 1;
        int n = (cnt > DW) ? DW : cnt;
        case (mode)
            1: return DW'(ones >> n);
            2: return DW'(ones & ~(ones >> n));
            default: return (n == DW) ? '0 : DW'(64'd1 << (DW - 1 - n));
        endcase
    endfunction

    function automatic int clz(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--)
            if (w[i]) return DW - 1 - i;
        return DW;
    endfunction

    logic [DW-1:0] qd[$];
    logic          qs[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qd.delete();
            qs.delete();
        end else begin
            bit acc, ret;
            acc = vld_i && (qd.size() < 2);
            ret = (qd.size() > 0) && rdy_i;
            if (ret) begin
                void'(qd.pop_front());
                void'(qs.pop_front());
            end
            if (acc) begin
                qd.push_back(ref_dec(int'(cnt_i), int'(mode_i)));
                qs.push_back(int'(cnt_i) > DW);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_vld", vld_o, qd.size() > 0);
            chk("model_rdy", rdy_o, qd.size() < 2);
            if (qd.size() > 0) begin
                chk("model_data", data_o, qd[0]);
                chk("model_sat", sat_o, qs[0]);
            end
        end
    end

    task automatic send(input int cnt, input int mode);
        vld_i  = 1'b1;
        cnt_i  = (LG+1)'(cnt);
        mode_i = 2'(mode);
        @(posedge clk);
        @(negedge clk);
        vld_i = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] d, input logic s);
        chk({name, "_vld"}, vld_o, 1);
        chk({name, "_data"}, data_o, d);
        chk({name, "_sat"}, sat_o, s);
    endtask

    initial begin
        rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b1; cnt_i = '0; mode_i = '0;
        #2;
        chk("reset_vld", vld_o, 0);
        chk("reset_rdy", rdy_o, 1);
        chk("reset_data", data_o, 0);
        rst = 1'b0;
        @(negedge clk);

        send(0, 0);  expect_out("m0_c0", 32'h8000_0000, 0);
        send(31, 0); expect_out("m0_c31", 32'h0000_0001, 0);
        send(5, 1);  expect_out("m1_c5", 32'h07FF_FFFF, 0);
        send(5, 2);  expect_out("m2_c5", 32'hF800_0000, 0);
        send(5, 3);  expect_out("m3_c5", 32'h0400_0000, 0);
        send(32, 1); expect_out("m1_c32", 32'h0000_0000, 0);
        send(40, 2); expect_out("m2_c40", 32'hFFFF_FFFF, 1);
        send(63, 0); expect_out("m0_c63", 32'h0000_0000, 1);
        @(negedge clk);

        // Backpressure: A and B fill both slots, C waits.
        rdy_i = 1'b0;
        send(1, 0);
        send(2, 0);
        chk("bp_rdy_low", rdy_o, 0);
        vld_i = 1'b1; cnt_i = 6'd3; mode_i = 2'd0;
        @(posedge clk); @(negedge clk);
        chk("bp_rdy_held", rdy_o, 0);
        expect_out("bp_a", 32'h4000_0000, 0);
        rdy_i = 1'b1;
        @(posedge clk); @(negedge clk);
        expect_out("bp_b", 32'h2000_0000, 0);
        @(posedge clk); @(negedge clk);
        vld_i = 1'b0;
        expect_out("bp_c", 32'h1000_0000, 0);
        @(negedge clk);
        chk("bp_drained", vld_o, 0);

        // Reset with both entries full, request already waiting on release.
        rdy_i = 1'b0;
        send(4, 0);
        send(6, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_vld", vld_o, 0);
        chk("rst_mid_rdy", rdy_o, 1);
        vld_i = 1'b1; cnt_i = 6'd7; mode_i = 2'd0; rdy_i = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        vld_i = 1'b0;
        expect_out("rst_first", 32'h0100_0000, 0);
        @(negedge clk);
        chk("rst_no_stale", vld_o, 0);

        // Round trip through a CLZ.
        for (int c = 0; c <= DW; c++) begin
            send(c, 0);
            chk("roundtrip_clz", clz(data_o), c);
        end

        // Random stream, random consumer stalls.
        for (int k = 0; k < 400; k++) begin
            vld_i  = 1'($urandom_range(0, 1));
            cnt_i  = 6'($urandom_range(0, 63));
            mode_i = 2'($urandom_range(0, 3));
            rdy_i  = ($urandom_range(0, 3) != 0);
            @(posedge clk); @(negedge clk);
        end
        vld_i = 1'b0; rdy_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_empty", vld_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
